// File: rtl/commit_trace_pkg.sv
// Shared definitions for the commit trace buffer: entry layout, flag bit positions, FSM states.
package commit_trace_pkg;

    localparam int PC_W   = 16;
    localparam int FLAG_W = 4;
    localparam int REG_W  = 3;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int ENTRY_W = PC_W + FLAG_W + REG_W + DATA_W + ADDR_W + DATA_W;

    localparam int FLAG_REG_WRITE = 0;
    localparam int FLAG_MEM_READ  = 1;
    localparam int FLAG_MEM_WRITE = 2;
    localparam int FLAG_HALT      = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_DONE   = 2'd2
    } stateT;

    // Field order is MSB first and defines the trace_entry bit layout.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [FLAG_W-1:0] flags;
        logic [REG_W-1:0]  wrReg;
        logic [DATA_W-1:0] wrData;
        logic [ADDR_W-1:0] memAddr;
        logic [DATA_W-1:0] memData;
    } entryT;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO: the head entry is presented combinationally from the storage array.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 71
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     rdEn,
    output logic [WIDTH-1:0]         rdData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtrReg;
    logic [AW-1:0]    rdPtrReg;
    logic [AW:0]      countReg;

    // Storage is deliberately left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtrReg] <= wrData;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (wrEn) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (rdEn) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
            case ({wrEn, rdEn})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    assign rdData = mem[rdPtrReg];
    assign count  = countReg;
    assign full   = (countReg == FULL_COUNT);
    assign empty  = (countReg == '0);

endmodule

// File: rtl/commit_trace_buf.sv
// Captures commit events into a drainable trace FIFO and tracks run/halt progress and counters.
module commit_trace_buf
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PC_W-1:0]          pc,
    input  logic                     reg_write,
    input  logic [REG_W-1:0]         wr_reg,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data_in,
    input  logic [DATA_W-1:0]        mem_data_out,
    input  logic                     halt,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [ENTRY_W-1:0]       trace_entry,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [31:0]              inst_count,
    output logic [31:0]              cycle_count,
    output logic                     halted,
    output logic                     done
);
    stateT stateReg, stateNext;

    logic                   isEvent;
    logic                   popReq;
    logic                   pushAccept;
    logic                   dropEvent;
    logic [FLAG_W-1:0]      flagsNext;
    entryT                  entryNext;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [$clog2(DEPTH):0] fifoCount;
    logic [ENTRY_W-1:0]     fifoOut;
    logic                   overflowReg;
    logic [15:0]            dropCountReg;
    logic [31:0]            instCountReg;
    logic [31:0]            cycleCountReg;

    assign isEvent    = (stateReg == ST_RUN) && (reg_write || mem_read || mem_write || halt);
    assign popReq     = !fifoEmpty && trace_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign pushAccept = isEvent && (!fifoFull || popReq);
    assign dropEvent  = isEvent && fifoFull && !popReq;

    always_comb begin
        flagsNext                 = '0;
        flagsNext[FLAG_REG_WRITE] = reg_write;
        flagsNext[FLAG_MEM_READ]  = mem_read;
        flagsNext[FLAG_MEM_WRITE] = mem_write;
        flagsNext[FLAG_HALT]      = halt;
    end

    always_comb begin
        entryNext         = '0;
        entryNext.pc      = pc;
        entryNext.flags   = flagsNext;
        entryNext.wrReg   = wr_reg;
        entryNext.wrData  = wr_data;
        entryNext.memAddr = mem_addr;
        entryNext.memData = mem_write ? mem_data_in : mem_data_out;
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (pushAccept),
        .wrData (entryNext),
        .rdEn   (popReq),
        .rdData (fifoOut),
        .count  (fifoCount),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= ST_RUN;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_RUN:    if (isEvent && halt) stateNext = ST_HALTED;
            ST_HALTED: if (fifoEmpty)       stateNext = ST_DONE;
            default:   stateNext = ST_DONE;
        endcase
    end

    always_comb begin
        halted = (stateReg != ST_RUN);
        done   = (stateReg == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflowReg   <= 1'b0;
            dropCountReg  <= '0;
            instCountReg  <= '0;
            cycleCountReg <= '0;
        end else begin
            if (dropEvent) begin
                overflowReg <= 1'b1;
                if (dropCountReg != 16'hFFFF) begin
                    dropCountReg <= dropCountReg + 16'd1;
                end
            end
            if (isEvent && (halt || reg_write || mem_write)) begin
                instCountReg <= instCountReg + 32'd1;
            end
            if (stateReg == ST_RUN) begin
                cycleCountReg <= cycleCountReg + 32'd1;
            end
        end
    end

    assign trace_valid = !fifoEmpty;
    assign trace_entry = fifoOut;
    assign occupancy   = fifoCount;
    assign overflow    = overflowReg;
    assign drop_count  = dropCountReg;
    assign inst_count  = instCountReg;
    assign cycle_count = cycleCountReg;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed bench for commit_trace_buf with a queue-based reference model checked every cycle.
module tb_commit_trace_buf;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        reg_write;
    logic [2:0]  wr_reg;
    logic [15:0] wr_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        halt;
    logic        trace_valid;
    logic        trace_ready;
    logic [70:0] trace_entry;
    logic [3:0]  occupancy;
    logic        overflow;
    logic [15:0] drop_count;
    logic [31:0] inst_count;
    logic [31:0] cycle_count;
    logic        halted;
    logic        done;

    commit_trace_buf #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .reg_write    (reg_write),
        .wr_reg       (wr_reg),
        .wr_data      (wr_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .halt         (halt),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_entry  (trace_entry),
        .occupancy    (occupancy),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .inst_count   (inst_count),
        .cycle_count  (cycle_count),
        .halted       (halted),
        .done         (done)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model state: 0 = run, 1 = halted, 2 = done.
    logic [70:0] mq[$];
    int          mState = 0;
    int unsigned mInst = 0;
    int unsigned mCycle = 0;
    bit          mOvf = 0;
    int          mDrop = 0;
    bit          started = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc = '0; reg_write = 0; wr_reg = '0; wr_data = '0; mem_read = 0; mem_write = 0;
        mem_addr = '0; mem_data_in = '0; mem_data_out = '0; halt = 0;
    endtask

    // Model update on every rising edge from the sampled inputs.
    initial begin
        bit          ev;
        bit          pop;
        int          prevSize;
        logic [15:0] md;
        logic [70:0] e;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                mState = 0; mInst = 0; mCycle = 0; mOvf = 0; mDrop = 0;
                started = 1;
            end else begin
                prevSize = mq.size();
                pop = (prevSize != 0) && trace_ready;
                ev = (mState == 0) && (reg_write || mem_read || mem_write || halt);
                if (pop) void'(mq.pop_front());
                if (ev) begin
                    md = mem_write ? mem_data_in : mem_data_out;
                    e = {pc, halt, mem_write, mem_read, reg_write, wr_reg, wr_data, mem_addr, md};
                    if (prevSize < DEPTH || pop) mq.push_back(e);
                    else begin
                        mOvf = 1;
                        if (mDrop < 65535) mDrop++;
                    end
                    if (halt || reg_write || mem_write) mInst++;
                end
                if (mState == 0) mCycle++;
                if (mState == 0 && ev && halt) mState = 1;
                else if (mState == 1 && prevSize == 0) mState = 2;
            end
        end
    end

    // Compare process: outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("trace_valid", 72'(trace_valid), 72'(mq.size() != 0));
                if (mq.size() != 0) check("trace_entry", 72'(trace_entry), 72'(mq[0]));
                check("occupancy", 72'(occupancy), 72'(mq.size()));
                check("overflow", 72'(overflow), 72'(mOvf));
                check("drop_count", 72'(drop_count), 72'(mDrop));
                check("inst_count", 72'(inst_count), 72'(mInst));
                check("cycle_count", 72'(cycle_count), 72'(mCycle));
                check("halted", 72'(halted), 72'(mState != 0));
                check("done", 72'(done), 72'(mState == 2));
            end
        end
    end

    initial begin
        logic [70:0] expEntry;
        idle();
        rst = 1; trace_ready = 0;
        tick(); tick();
        check("rst_valid", 72'(trace_valid), 72'(0));
        check("rst_occ", 72'(occupancy), 72'(0));
        check("rst_inst", 72'(inst_count), 72'(0));
        check("rst_cycle", 72'(cycle_count), 72'(0));
        check("rst_halted", 72'(halted), 72'(0));
        check("rst_done", 72'(done), 72'(0));
        rst = 0;

        // Register write event
        trace_ready = 1; pc = 16'h0010; reg_write = 1; wr_reg = 3'd3; wr_data = 16'h1234;
        tick(); idle();
        expEntry = {16'h0010, 4'b0001, 3'd3, 16'h1234, 16'h0000, 16'h0000};
        check("rw_valid", 72'(trace_valid), 72'(1));
        check("rw_entry", 72'(trace_entry), 72'(expEntry));
        check("rw_inst", 72'(inst_count), 72'(1));
        tick();
        check("rw_popped", 72'(trace_valid), 72'(0));

        // Load with register write
        pc = 16'h0014; reg_write = 1; mem_read = 1; wr_reg = 3'd1; wr_data = 16'h00AA;
        mem_addr = 16'h0040; mem_data_out = 16'hBEEF; mem_data_in = 16'h5555;
        tick(); idle();
        expEntry = {16'h0014, 4'b0011, 3'd1, 16'h00AA, 16'h0040, 16'hBEEF};
        check("ld_entry", 72'(trace_entry), 72'(expEntry));
        check("ld_inst", 72'(inst_count), 72'(2));
        tick();

        // Both memory qualifiers: store data wins
        pc = 16'h0018; mem_read = 1; mem_write = 1; mem_addr = 16'h0080;
        mem_data_in = 16'h1111; mem_data_out = 16'h2222;
        tick(); idle();
        expEntry = {16'h0018, 4'b0110, 3'd0, 16'h0000, 16'h0080, 16'h1111};
        check("st_entry", 72'(trace_entry), 72'(expEntry));
        check("st_inst", 72'(inst_count), 72'(3));
        tick();

        // Ten events into a stalled FIFO
        trace_ready = 0;
        for (int i = 0; i < 10; i++) begin
            reg_write = 1; wr_reg = 3'(i); wr_data = 16'h0100 + 16'(i); pc = 16'h0100 + 16'(2 * i);
            tick(); idle();
        end
        check("ovf_occ", 72'(occupancy), 72'(8));
        check("ovf_flag", 72'(overflow), 72'(1));
        check("ovf_drops", 72'(drop_count), 72'(2));
        check("ovf_head", 72'(trace_entry[47:32]), 72'(16'h0100));

        // Push and pop while full
        trace_ready = 1; reg_write = 1; wr_data = 16'h0200;
        tick(); idle(); trace_ready = 0;
        check("fullpp_occ", 72'(occupancy), 72'(8));
        check("fullpp_drops", 72'(drop_count), 72'(2));
        check("fullpp_head", 72'(trace_entry[47:32]), 72'(16'h0101));

        trace_ready = 1;
        for (int i = 0; i < 10; i++) tick();
        check("drain_occ", 72'(occupancy), 72'(0));
        check("drain_inst", 72'(inst_count), 72'(14));
        check("drain_ovf_sticky", 72'(overflow), 72'(1));

        // Halt with three entries buffered
        trace_ready = 0;
        reg_write = 1; wr_data = 16'h0300; tick();
        wr_data = 16'h0301; tick(); idle();
        halt = 1; pc = 16'h0400; tick(); idle();
        check("halt_halted", 72'(halted), 72'(1));
        check("halt_occ", 72'(occupancy), 72'(3));
        check("halt_done", 72'(done), 72'(0));
        reg_write = 1; mem_write = 1; halt = 1;
        for (int i = 0; i < 4; i++) tick();
        check("halt_ignored_occ", 72'(occupancy), 72'(3));
        check("halt_ignored_inst", 72'(inst_count), 72'(17));
        trace_ready = 1;
        for (int k = 0; k < 30 && done !== 1'b1; k++) tick();
        idle();
        check("halt_done_reached", 72'(done), 72'(1));
        check("halt_done_occ", 72'(occupancy), 72'(0));

        // Reset while halted with two entries
        rst = 1; tick(); rst = 0;
        trace_ready = 0;
        reg_write = 1; wr_data = 16'h0500; tick(); idle();
        halt = 1; tick(); idle();
        check("rh_halted", 72'(halted), 72'(1));
        check("rh_occ", 72'(occupancy), 72'(2));
        rst = 1; reg_write = 1; tick(); rst = 0; idle();
        check("rh_valid", 72'(trace_valid), 72'(0));
        check("rh_occ0", 72'(occupancy), 72'(0));
        check("rh_inst", 72'(inst_count), 72'(0));
        check("rh_cycle", 72'(cycle_count), 72'(0));
        check("rh_drops", 72'(drop_count), 72'(0));
        check("rh_halted0", 72'(halted), 72'(0));
        tick();
        check("rh_run_cycle", 72'(cycle_count), 72'(1));
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/commit_trace_buf.md
COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pc  input  16  PC of the committing instruction.
REQ-005 SHALL have port reg_write  input  1  register file written this cycle.
REQ-006 SHALL have port wr_reg  input  3  destination register.
REQ-007 SHALL have port wr_data  input  16  register write data.
REQ-008 SHALL have port mem_read, mem_write  input  1 each  memory access qualifiers.
REQ-009 SHALL have port mem_addr, mem_data_in, mem_data_out  input  16 each  address, store data, load data.
REQ-010 SHALL have port halt  input  1  halt in memory/writeback stage.
REQ-011 SHALL have port trace_valid  output  1 and trace_ready  input  1  drain handshake.
REQ-012 SHALL have port trace_entry  output  71  {pc, flags[3:0]={halt,mem_write,mem_read,reg_write}, wr_reg, wr_data, mem_addr, mem_data}.
REQ-013 SHALL have ports occupancy  output  $clog2(DEPTH)+1; overflow  output  1 sticky; drop_count  output  16.
REQ-014 SHALL have ports inst_count, cycle_count  output  32 each; halted, done  output  1 each.

Function
REQ-015 SHALL, while in state RUN, treat a cycle as an event when any of reg_write, mem_read, mem_write, halt is 1.
REQ-016 SHALL form mem_data = mem_write ? mem_data_in : mem_data_out; store wins if both qualifiers high.
REQ-017 SHALL push one entry per event; pushed entry visible on trace_entry with trace_valid=1 one cycle after the event when FIFO was empty.
REQ-018 SHALL pop on trace_valid & trace_ready; trace_entry holds stable while trace_valid=1 and trace_ready=0.
REQ-019 SHALL, on push with FIFO full and no pop same cycle, drop the event, set overflow, increment drop_count (saturating at 0xFFFF).
REQ-020 SHALL accept push when full if a pop occurs the same cycle; occupancy unchanged.
REQ-021 SHALL accept simultaneous push and pop when empty-plus-one-entry without loss or reorder; strict FIFO order.
REQ-022 SHALL wrap read/write pointers modulo DEPTH.
REQ-023 SHALL increment inst_count in RUN when halt|reg_write|mem_write; wraps at 2^32.
REQ-024 SHALL increment cycle_count every RUN cycle; frozen outside RUN; wraps at 2^32.
REQ-025 SHALL implement FSM RUN -> HALTED (on halt event in RUN, after capturing it, even if dropped) -> DONE (HALTED and occupancy==0); DONE terminal until rst.
REQ-026 SHALL ignore all event inputs in HALTED and DONE; draining continues in HALTED.
REQ-027 SHALL drive halted=1 in HALTED and DONE, done=1 only in DONE.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter RUN, empty the FIFO, clear occupancy, overflow, drop_count, inst_count, cycle_count, halted, done, trace_valid; input events that cycle are discarded.
REQ-029 SHALL apply reset mid-drain/mid-halt identically; buffered entries are lost.
REQ-030 SHALL keep FIFO storage array unreset; trace_entry undefined while trace_valid=0.

Structure
REQ-031 SHALL take entry field widths, flag bit positions and FSM state encodings from a shared package, commit_trace_pkg.
REQ-032 SHALL place storage and pointers in one sub-module, trace_fifo, parameterised by DEPTH and width.
REQ-033 SHALL keep FSM, counters and entry packing in commit_trace_buf.

Verification
REQ-034 SHALL cover: reg_write=1, wr_reg=3, wr_data=0x1234, pc=0x0010, ready=1 -> next cycle trace_valid=1, flags=0001, entry fields match; inst_count=1.
REQ-035 SHALL cover: mem_read=1, reg_write=1, mem_addr=0x0040, mem_data_out=0xBEEF -> one entry flags=0011, mem_data=0xBEEF; inst_count increments by 1.
REQ-036 SHALL cover: ready=0, DEPTH=8, 10 events -> occupancy=8, overflow=1, drop_count=2; then ready=1 drains first 8 in order.
REQ-037 SHALL cover: full FIFO, push and pop same cycle -> occupancy stays 8, drop_count unchanged.
REQ-038 SHALL cover: halt with 3 entries buffered -> halted=1, later events ignored, cycle_count frozen, done=1 the cycle after last pop.
REQ-039 SHALL cover: rst asserted in HALTED with 2 entries -> next cycle trace_valid=0, occupancy=0, all counters 0, state RUN.
